// File: rtl/sar_pkg.sv
// Shared types and constant helpers for the successive-approximation search engine.
package sar_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EVAL   = 2'd1,
        ST_VERIFY = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Ceiling log2 usable in constant expressions (returns 0 for v <= 1).
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned k = 0; k < 32; k++) begin
            if ((64'd1 << k) < 64'(v)) r = k + 1;
        end
        return r;
    endfunction

    // First probe of a search: only the MSB set.
    function automatic logic [31:0] msb_probe(input int unsigned w);
        return 32'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/sar_wait_cnt.sv
// Loadable down-counter that holds off flag sampling while the comparator settles.
module sar_wait_cnt #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero_c
);

    logic [W-1:0] cnt;

    // Load wins; otherwise count down and stick at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero_c = (cnt == '0);

endmodule

// File: rtl/sar_search.sv
// Successive-approximation search driving comparator A, MSB first, against a hidden B.
// Optional feature: define SAR_VERIFY_EN to add a final confirm compare of the result.
module sar_search
    import sar_pkg::*;
#(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned CMP_LAT = 0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    output logic [WIDTH-1:0]            probe,
    input  logic                        cmp_g,
    input  logic                        cmp_e,
    input  logic                        cmp_l,
    output logic                        busy,
    output logic                        done,
    output logic [WIDTH-1:0]            result,
    output logic                        found,
    output logic                        err,
    output logic [clog2(WIDTH+2)-1:0]   steps
);

    localparam int unsigned SW = clog2(WIDTH + 2);
    localparam int unsigned IW = clog2(WIDTH);
    localparam int unsigned CW = (CMP_LAT == 0) ? 1 : clog2(CMP_LAT + 1);
    localparam logic [WIDTH-1:0] MSB = WIDTH'(msb_probe(WIDTH));

    state_t           state;
    state_t           state_nxt;
    logic [IW-1:0]    idx;
    logic [IW-1:0]    idx_nxt;
    logic [WIDTH-1:0] probe_nxt;
    logic [WIDTH-1:0] result_nxt;
    logic [WIDTH-1:0] work_c;
    logic [SW-1:0]    steps_nxt;
    logic             busy_nxt;
    logic             done_nxt;
    logic             found_nxt;
    logic             err_nxt;
    logic             cnt_load_c;
    logic             cnt_zero_c;
    logic             flags_ok_c;

    assign flags_ok_c = $onehot({cmp_g, cmp_e, cmp_l});

    sar_wait_cnt #(
        .W(CW)
    ) u_wait (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load_c),
        .load_val (CW'(CMP_LAT)),
        .zero_c   (cnt_zero_c)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state selection; flags only matter once the settle counter has drained.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start) state_nxt = ST_EVAL;
            end
            ST_EVAL: begin
                if (cnt_zero_c) begin
                    if (!flags_ok_c || cmp_e) begin
                        state_nxt = ST_DONE;
                    end else if (idx == '0) begin
`ifdef SAR_VERIFY_EN
                        state_nxt = ST_VERIFY;
`else
                        state_nxt = ST_DONE;
`endif
                    end
                end
            end
`ifdef SAR_VERIFY_EN
            ST_VERIFY: begin
                if (cnt_zero_c) state_nxt = ST_DONE;
            end
`endif
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Datapath next values: probe/bit walk, result capture and status flags.
    always_comb begin
        idx_nxt    = idx;
        probe_nxt  = probe;
        result_nxt = result;
        steps_nxt  = steps;
        busy_nxt   = busy;
        done_nxt   = 1'b0;
        found_nxt  = found;
        err_nxt    = err;
        cnt_load_c = 1'b0;
        work_c     = probe;
        if (cmp_g) work_c[idx] = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    probe_nxt  = MSB;
                    idx_nxt    = IW'(WIDTH - 1);
                    cnt_load_c = 1'b1;
                    steps_nxt  = '0;
                    found_nxt  = 1'b0;
                    err_nxt    = 1'b0;
                    busy_nxt   = 1'b1;
                end
            end
            ST_EVAL: begin
                if (cnt_zero_c) begin
                    steps_nxt = steps + SW'(1);
                    if (!flags_ok_c) begin
                        err_nxt   = 1'b1;
                        found_nxt = 1'b0;
                    end else if (cmp_e) begin
                        result_nxt = probe;
                        found_nxt  = 1'b1;
                    end else if (idx == '0) begin
                        result_nxt = work_c;
`ifdef SAR_VERIFY_EN
                        probe_nxt  = work_c;
                        cnt_load_c = 1'b1;
`else
                        found_nxt  = 1'b1;
`endif
                    end else begin
                        probe_nxt  = work_c | (WIDTH'(1) << (idx - IW'(1)));
                        idx_nxt    = idx - IW'(1);
                        cnt_load_c = 1'b1;
                    end
                end
            end
`ifdef SAR_VERIFY_EN
            ST_VERIFY: begin
                if (cnt_zero_c) begin
                    steps_nxt = steps + SW'(1);
                    if (!flags_ok_c) begin
                        err_nxt   = 1'b1;
                        found_nxt = 1'b0;
                    end else begin
                        found_nxt = cmp_e;
                    end
                end
            end
`endif
            ST_DONE: begin
                done_nxt = 1'b1;
                busy_nxt = 1'b0;
            end
            default: begin
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx    <= '0;
            probe  <= '0;
            result <= '0;
            steps  <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            found  <= 1'b0;
            err    <= 1'b0;
        end else begin
            idx    <= idx_nxt;
            probe  <= probe_nxt;
            result <= result_nxt;
            steps  <= steps_nxt;
            busy   <= busy_nxt;
            done   <= done_nxt;
            found  <= found_nxt;
            err    <= err_nxt;
        end
    end

endmodule

// File: tb/tb_sar_search.sv
// Bench for sar_search: a zero-latency and a two-cycle-latency instance against a hidden value.
module tb_sar_search;

    localparam int unsigned W = 4;

    typedef struct {
        logic [W-1:0] hid;
        int           res;
        int           steps;
        int           found;
        int           err;
        int           cyc;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic sel = 1'b0;
    logic [W-1:0] hid = '0;
    always #5 clk = ~clk;

    logic start0, start2;
    assign start0 = start & ~sel;
    assign start2 = start & sel;

    logic [W-1:0] probe0, probe2, result0, result2;
    logic busy0, busy2, done0, done2, found0, found2, err0, err2;
    logic [2:0] steps0, steps2;

    logic force_en = 1'b0;
    logic [2:0] force_val = 3'b000;
    logic g0, e0, l0;
    assign {g0, e0, l0} = force_en ? force_val : {probe0 > hid, probe0 == hid, probe0 < hid};

    // Slow comparator: garbage flags for two cycles after each probe change.
    logic g2 = 1'b0, e2 = 1'b0, l2 = 1'b0;
    logic [W-1:0] last2 = '0;
    int age2 = 3;
    always @(negedge clk) begin
        if (probe2 != last2) begin
            last2 = probe2;
            age2 = 0;
        end else if (age2 < 3) begin
            age2++;
        end
        if (age2 < 2) {g2, e2, l2} = 3'($urandom);
        else {g2, e2, l2} = {probe2 > hid, probe2 == hid, probe2 < hid};
    end

    sar_search #(.WIDTH(W), .CMP_LAT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .probe(probe0),
        .cmp_g(g0), .cmp_e(e0), .cmp_l(l0), .busy(busy0), .done(done0),
        .result(result0), .found(found0), .err(err0), .steps(steps0)
    );

    sar_search #(.WIDTH(W), .CMP_LAT(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .probe(probe2),
        .cmp_g(g2), .cmp_e(e2), .cmp_l(l2), .busy(busy2), .done(done2),
        .result(result2), .found(found2), .err(err2), .steps(steps2)
    );

    logic [W-1:0] probe_s, result_s;
    logic busy_s, done_s, found_s, err_s;
    logic [2:0] steps_s;
    assign probe_s  = sel ? probe2  : probe0;
    assign result_s = sel ? result2 : result0;
    assign busy_s   = sel ? busy2   : busy0;
    assign done_s   = sel ? done2   : done0;
    assign found_s  = sel ? found2  : found0;
    assign err_s    = sel ? err2    : err0;
    assign steps_s  = sel ? steps2  : steps0;

    // Record the distinct probe values issued during a search.
    logic [W-1:0] pq[$];
    always @(negedge clk) begin
        if (busy_s && (pq.size() == 0 || pq[$] != probe_s)) pq.push_back(probe_s);
    end

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Reference: binary search on the integer line, one compare per bit.
    function automatic void ref_model(input int h, input int lat, output vec_t v, output longint pk);
        int trial;
        int p;
        bit hit;
        trial = 0;
        p = 0;
        hit = 0;
        pk = 0;
        v.hid = W'(h);
        v.steps = 0;
        v.err = 0;
        v.found = 1;
        v.res = 0;
        for (int b = W - 1; b >= 0 && !hit; b--) begin
            p = trial + (1 << b);
            v.steps++;
            pk = (pk << 4) | longint'(p);
            if (p == h) begin
                hit = 1;
                v.res = p;
            end else if (p < h) begin
                trial = p;
            end
        end
        if (!hit) begin
            v.res = trial;
`ifdef SAR_VERIFY_EN
            v.steps++;
            if (trial != p) pk = (pk << 4) | longint'(trial);
            v.found = (trial == h) ? 1 : 0;
`endif
        end
        v.cyc = v.steps * (lat + 1) + 1;
    endfunction

    task automatic run(input logic d, input vec_t v, input int poke, input longint exp_pk, input string tag);
        int cyc;
        longint pk;
        sel = d;
        hid = v.hid;
        @(negedge clk);
        pq.delete();
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk({tag, "/busy_start"}, busy_s, 1);
        cyc = 0;
        while (cyc < 80) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (done_s) break;
            start = (cyc == poke);
        end
        start = 1'b0;
        chk({tag, "/done_cycle"}, cyc, v.cyc);
        if (v.res >= 0) chk({tag, "/result"}, result_s, v.res);
        chk({tag, "/steps"}, steps_s, v.steps);
        chk({tag, "/found"}, found_s, v.found);
        chk({tag, "/err"}, err_s, v.err);
        chk({tag, "/busy_done"}, busy_s, 0);
        if (exp_pk >= 0) begin
            pk = 0;
            foreach (pq[k]) pk = (pk << 4) | longint'(pq[k]);
            chk({tag, "/probes"}, pk, exp_pk);
        end
        @(negedge clk);
        chk({tag, "/done_pulse"}, done_s, 0);
        chk({tag, "/idle"}, busy_s, 0);
    endtask

    initial begin
        vec_t tbl[$];
        vec_t v;
        longint pk;
        int h;

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset/probe", probe0, 0);
        chk("reset/busy_done", {busy0, done0, found0, err0}, 0);
        chk("reset/result_steps", {result0, steps0}, 0);
        rst_n = 1'b1;

        // Hand-derived vectors: {hidden, result, steps, found, err, done cycle}.
        tbl.push_back('{4'd11, 11, 4, 1, 0, 5});
        tbl.push_back('{4'd8,   8, 1, 1, 0, 2});
`ifdef SAR_VERIFY_EN
        tbl.push_back('{4'd0,   0, 5, 1, 0, 6});
`else
        tbl.push_back('{4'd0,   0, 4, 1, 0, 5});
`endif
        tbl.push_back('{4'd15, 15, 4, 1, 0, 5});
        tbl.push_back('{4'd6,   6, 3, 1, 0, 4});
        tbl.push_back('{4'd12, 12, 2, 1, 0, 3});
        tbl.push_back('{4'd1,   1, 4, 1, 0, 5});
        for (int k = 0; k < tbl.size(); k++) begin
            ref_model(int'(tbl[k].hid), 0, v, pk);
            run(1'b0, tbl[k], 0, pk, $sformatf("tbl%0d", k));
        end

        // Reset mid-search clears every output asynchronously.
        sel = 1'b0;
        hid = 4'd11;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst/probe", probe0, 0);
        chk("midrst/result", result0, 0);
        chk("midrst/flags", {busy0, done0, found0, err0, steps0}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run(1'b0, '{4'd9, 9, 4, 1, 0, 5}, 2, 64'h8CA9, "after_rst");

        // Start pulses mid-search and during the DONE cycle are ignored.
        run(1'b0, '{4'd11, 11, 4, 1, 0, 5}, 4, 64'h8CAB, "poke_done");

        // Non-one-hot flags terminate with err.
        force_en = 1'b1;
        force_val = 3'b101;
        run(1'b0, '{4'd3, -1, 1, 0, 1, 2}, 0, -1, "err_gl");
        force_val = 3'b000;
        run(1'b0, '{4'd3, -1, 1, 0, 1, 2}, 0, -1, "err_none");
        force_val = 3'b110;
        run(1'b0, '{4'd3, -1, 1, 0, 1, 2}, 0, -1, "err_ge");
        force_en = 1'b0;

        // Randomized hidden values on the combinational comparator.
        for (int k = 0; k < 16; k++) begin
            h = int'($urandom_range(0, 15));
            ref_model(h, 0, v, pk);
            run(1'b0, v, int'($urandom_range(1, 3)), pk, $sformatf("rnd0_%0d_h%0d", k, h));
        end

        // Slow comparator with garbage flags while settling.
        ref_model(5, 2, v, pk);
        chk("lat2/model_h5_cyc", v.cyc, 13);
        run(1'b1, '{4'd5, 5, 4, 1, 0, 13}, 5, pk, "lat2_h5");
        ref_model(0, 2, v, pk);
        run(1'b1, v, 0, pk, "lat2_h0");
        ref_model(15, 2, v, pk);
        run(1'b1, v, 0, pk, "lat2_h15");
        for (int k = 0; k < 6; k++) begin
            h = int'($urandom_range(0, 15));
            ref_model(h, 2, v, pk);
            run(1'b1, v, int'($urandom_range(1, 8)), pk, $sformatf("rnd2_%0d_h%0d", k, h));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
